// File: rtl/alu_pkg.sv
// Shared types for the ALU and its two-requester round-robin arbiter.
package alu_pkg;

  localparam int STAT_W = 16;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100
  } alu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } arb_state_e;

  // Opcodes 101..111 are reserved and reported as errors.
  function automatic logic alu_op_legal(input logic [2:0] op);
    return (op <= 3'b100);
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU: add/sub/and/or/xor evaluated W+1 bits wide so bit W is carry/borrow.
module alu
  import alu_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [2:0]   op_i,
  output logic [W-1:0] y_o,
  output logic         zero_o,
  output logic         carry_o
);

  logic [W:0] wide_s;

  always_comb begin
    wide_s = '0;
    case (op_i)
      ALU_ADD: wide_s = {1'b0, a_i} + {1'b0, b_i};
      ALU_SUB: wide_s = {1'b0, a_i} - {1'b0, b_i};
      ALU_AND: wide_s = {1'b0, a_i & b_i};
      ALU_OR:  wide_s = {1'b0, a_i | b_i};
      ALU_XOR: wide_s = {1'b0, a_i ^ b_i};
      default: wide_s = '0;
    endcase
  end

  assign y_o     = wide_s[W-1:0];
  assign carry_o = wide_s[W];
  assign zero_o  = (wide_s[W-1:0] == '0);

endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter feeding one shared ALU, with a single registered response slot.
// Optional grant counters are built when ALU_ARB_STATS_EN is defined.
module alu_rr_arbiter
  import alu_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic [2:0]   req0_op,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic [2:0]   req1_op,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_y,
  output logic         rsp_zero,
  output logic         rsp_carry,
  output logic         rsp_err
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_gnt0,
  output logic [STAT_W-1:0] stat_gnt1
`endif
);

  arb_state_e   state_q, state_d;
  logic         last_gnt_q, last_gnt_d;
  logic         rsp_id_q, rsp_id_d;
  logic [W-1:0] rsp_y_q, rsp_y_d;
  logic         rsp_zero_q, rsp_zero_d;
  logic         rsp_carry_q, rsp_carry_d;
  logic         rsp_err_q, rsp_err_d;

  logic         gnt0, gnt1, issue_ok, acc0, acc1, accept;
  logic [W-1:0] alu_a, alu_b, alu_y;
  logic [2:0]   alu_op;
  logic         alu_zero, alu_carry;

  // Grant depends only on valids and last_gnt, never on payload, so ready stays payload-free.
  assign gnt0     = req0_valid && (!req1_valid || last_gnt_q);
  assign gnt1     = req1_valid && (!req0_valid || !last_gnt_q);
  assign issue_ok = (state_q == IDLE) || rsp_ready;
  assign req0_ready = gnt0 && issue_ok;
  assign req1_ready = gnt1 && issue_ok;
  assign acc0   = req0_valid && req0_ready;
  assign acc1   = req1_valid && req1_ready;
  assign accept = acc0 || acc1;

  always_comb begin
    alu_a  = req0_a;
    alu_b  = req0_b;
    alu_op = req0_op;
    if (gnt1) begin
      alu_a  = req1_a;
      alu_b  = req1_b;
      alu_op = req1_op;
    end else begin
      alu_a  = req0_a;
      alu_b  = req0_b;
      alu_op = req0_op;
    end
  end

  alu #(.W(W)) u_alu (
    .a_i    (alu_a),
    .b_i    (alu_b),
    .op_i   (alu_op),
    .y_o    (alu_y),
    .zero_o (alu_zero),
    .carry_o(alu_carry)
  );

  always_comb begin
    state_d     = state_q;
    last_gnt_d  = last_gnt_q;
    rsp_id_d    = rsp_id_q;
    rsp_y_d     = rsp_y_q;
    rsp_zero_d  = rsp_zero_q;
    rsp_carry_d = rsp_carry_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = RESP;
        else        state_d = IDLE;
      end
      RESP: begin
        if (rsp_ready && !accept) state_d = IDLE;
        else                      state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      last_gnt_d  = acc1;
      rsp_id_d    = acc1;
      rsp_y_d     = alu_y;
      rsp_zero_d  = alu_zero;
      rsp_carry_d = alu_carry;
      rsp_err_d   = !alu_op_legal(alu_op);
    end else begin
      last_gnt_d  = last_gnt_q;
      rsp_id_d    = rsp_id_q;
    end
  end

  // last_gnt resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_gnt_q  <= 1'b1;
      rsp_id_q    <= 1'b0;
      rsp_y_q     <= '0;
      rsp_zero_q  <= 1'b0;
      rsp_carry_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_gnt_q  <= last_gnt_d;
      rsp_id_q    <= rsp_id_d;
      rsp_y_q     <= rsp_y_d;
      rsp_zero_q  <= rsp_zero_d;
      rsp_carry_q <= rsp_carry_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = rsp_id_q;
  assign rsp_y     = rsp_y_q;
  assign rsp_zero  = rsp_zero_q;
  assign rsp_carry = rsp_carry_q;
  assign rsp_err   = rsp_err_q;

`ifdef ALU_ARB_STATS_EN
  logic [STAT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  // Saturating acceptance counters.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (acc0 && (cnt0_q != {STAT_W{1'b1}})) cnt0_d = cnt0_q + {{(STAT_W-1){1'b0}}, 1'b1};
    else                                    cnt0_d = cnt0_q;
    if (acc1 && (cnt1_q != {STAT_W{1'b1}})) cnt1_d = cnt1_q + {{(STAT_W-1){1'b0}}, 1'b1};
    else                                    cnt1_d = cnt1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign stat_gnt0 = cnt0_q;
  assign stat_gnt1 = cnt1_q;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed self-checking bench for alu_rr_arbiter (W=4); covers counters when ALU_ARB_STATS_EN is set.
module tb_alu_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0] req0_op, req1_op;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_carry, rsp_err;
  logic [3:0] rsp_y;
`ifdef ALU_ARB_STATS_EN
  logic [15:0] stat_gnt0, stat_gnt1;
`endif

  int total = 0;
  int bad   = 0;

  // {valid, id, y[3:0], zero, carry, err}
  logic [8:0] rsp_s;
  assign rsp_s = {rsp_valid, rsp_id, rsp_y, rsp_zero, rsp_carry, rsp_err};

  alu_rr_arbiter #(.W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0_valid(req0_valid),
    .req0_ready(req0_ready),
    .req0_a    (req0_a),
    .req0_b    (req0_b),
    .req0_op   (req0_op),
    .req1_valid(req1_valid),
    .req1_ready(req1_ready),
    .req1_a    (req1_a),
    .req1_b    (req1_b),
    .req1_op   (req1_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_y     (rsp_y),
    .rsp_zero  (rsp_zero),
    .rsp_carry (rsp_carry),
    .rsp_err   (rsp_err)
`ifdef ALU_ARB_STATS_EN
    ,
    .stat_gnt0 (stat_gnt0),
    .stat_gnt1 (stat_gnt1)
`endif
  );

  always #5 clk = ~clk;

  task automatic drain;
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset;
    #2;
    if (rsp_s !== 9'h000) begin bad = bad + 1; $display("FAIL reset_rsp got=%h exp=%h", rsp_s, 9'h000); end
    total = total + 1;
    if ({req0_ready, req1_ready} !== 2'b00) begin bad = bad + 1; $display("FAIL reset_ready got=%b exp=00", {req0_ready, req1_ready}); end
    total = total + 1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_add;
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 4'd9; req0_b = 4'd8; req0_op = 3'b000; rsp_ready = 1'b1;
    #1;
    if (req0_ready !== 1'b1) begin bad = bad + 1; $display("FAIL add_ready got=%b exp=1", req0_ready); end
    total = total + 1;
    @(negedge clk);
    req0_valid = 1'b0;
    if (rsp_s !== {1'b1, 1'b0, 4'd1, 1'b0, 1'b1, 1'b0}) begin bad = bad + 1; $display("FAIL add_rsp got=%h exp=%h", rsp_s, {1'b1, 1'b0, 4'd1, 1'b0, 1'b1, 1'b0}); end
    total = total + 1;
    drain();
  endtask

  task automatic test_sub;
    @(negedge clk);
    req1_valid = 1'b1; req1_a = 4'd3; req1_b = 4'd5; req1_op = 3'b001; rsp_ready = 1'b1;
    #1;
    if (req1_ready !== 1'b1) begin bad = bad + 1; $display("FAIL sub_ready got=%b exp=1", req1_ready); end
    total = total + 1;
    @(negedge clk);
    if (rsp_s !== {1'b1, 1'b1, 4'd14, 1'b0, 1'b1, 1'b0}) begin bad = bad + 1; $display("FAIL sub_borrow got=%h exp=%h", rsp_s, {1'b1, 1'b1, 4'd14, 1'b0, 1'b1, 1'b0}); end
    total = total + 1;
    // back-to-back: next request accepted while the previous response drains
    req1_a = 4'd5; req1_b = 4'd5;
    #1;
    if (req1_ready !== 1'b1) begin bad = bad + 1; $display("FAIL b2b_ready got=%b exp=1", req1_ready); end
    total = total + 1;
    @(negedge clk);
    req1_valid = 1'b0;
    if (rsp_s !== {1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0}) begin bad = bad + 1; $display("FAIL sub_zero got=%h exp=%h", rsp_s, {1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0}); end
    total = total + 1;
    drain();
  endtask

  task automatic test_fairness;
    logic       e;
    logic [8:0] exp_s;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd1; req0_op = 3'b000;
    req1_valid = 1'b1; req1_a = 4'd2; req1_b = 4'd3; req1_op = 3'b011;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      e = i[0];
      #1;
      if ({req0_ready, req1_ready} !== {~e, e}) begin bad = bad + 1; $display("FAIL fair_ready[%0d] got=%b exp=%b", i, {req0_ready, req1_ready}, {~e, e}); end
      total = total + 1;
      @(negedge clk);
      exp_s = e ? {1'b1, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0} : {1'b1, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0};
      if (rsp_s !== exp_s) begin bad = bad + 1; $display("FAIL fair_rsp[%0d] got=%h exp=%h", i, rsp_s, exp_s); end
      total = total + 1;
    end
    drain();
  endtask

  task automatic test_backpressure;
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 4'd4; req0_b = 4'd3; req0_op = 3'b000; rsp_ready = 1'b0;
    #1;
    if (req0_ready !== 1'b1) begin bad = bad + 1; $display("FAIL bp_idle_ready got=%b exp=1", req0_ready); end
    total = total + 1;
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 4'd6; req1_b = 4'd3; req1_op = 3'b100;
    if (rsp_s !== {1'b1, 1'b0, 4'd7, 1'b0, 1'b0, 1'b0}) begin bad = bad + 1; $display("FAIL bp_first got=%h exp=%h", rsp_s, {1'b1, 1'b0, 4'd7, 1'b0, 1'b0, 1'b0}); end
    total = total + 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      if ({req0_ready, req1_ready} !== 2'b00) begin bad = bad + 1; $display("FAIL bp_ready[%0d] got=%b exp=00", k, {req0_ready, req1_ready}); end
      total = total + 1;
      @(negedge clk);
      if (rsp_s !== {1'b1, 1'b0, 4'd7, 1'b0, 1'b0, 1'b0}) begin bad = bad + 1; $display("FAIL bp_hold[%0d] got=%h exp=%h", k, rsp_s, {1'b1, 1'b0, 4'd7, 1'b0, 1'b0, 1'b0}); end
      total = total + 1;
    end
    rsp_ready = 1'b1;
    #1;
    if (req1_ready !== 1'b1) begin bad = bad + 1; $display("FAIL bp_release_ready got=%b exp=1", req1_ready); end
    total = total + 1;
    @(negedge clk);
    req1_valid = 1'b0;
    if (rsp_s !== {1'b1, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0}) begin bad = bad + 1; $display("FAIL bp_second got=%h exp=%h", rsp_s, {1'b1, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0}); end
    total = total + 1;
    drain();
  endtask

  task automatic test_illegal_op;
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 4'd7; req0_b = 4'd2; req0_op = 3'b110; rsp_ready = 1'b1;
    @(negedge clk);
    req0_valid = 1'b0;
    if (rsp_s !== {1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1}) begin bad = bad + 1; $display("FAIL illegal_op got=%h exp=%h", rsp_s, {1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1}); end
    total = total + 1;
    drain();
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd2; req0_op = 3'b000; rsp_ready = 1'b0;
    @(negedge clk);
    req0_valid = 1'b0;
    if (rsp_s !== {1'b1, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0}) begin bad = bad + 1; $display("FAIL rmid_pre got=%h exp=%h", rsp_s, {1'b1, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0}); end
    total = total + 1;
    #2;
    rst_n = 1'b0;
    #1;
    if (rsp_s !== 9'h000) begin bad = bad + 1; $display("FAIL rmid_async got=%h exp=%h", rsp_s, 9'h000); end
    total = total + 1;
`ifdef ALU_ARB_STATS_EN
    if ({stat_gnt0, stat_gnt1} !== 32'h0) begin bad = bad + 1; $display("FAIL rmid_stats got=%h exp=0", {stat_gnt0, stat_gnt1}); end
    total = total + 1;
`endif
    @(negedge clk);
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_a = 4'd2; req0_b = 4'd2; req0_op = 3'b000;
    req1_valid = 1'b1; req1_a = 4'd1; req1_b = 4'd1; req1_op = 3'b010;
    rsp_ready = 1'b1;
    #1;
    if ({req0_ready, req1_ready} !== 2'b10) begin bad = bad + 1; $display("FAIL rmid_first_gnt got=%b exp=10", {req0_ready, req1_ready}); end
    total = total + 1;
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    if (rsp_s !== {1'b1, 1'b0, 4'd4, 1'b0, 1'b0, 1'b0}) begin bad = bad + 1; $display("FAIL rmid_rsp got=%h exp=%h", rsp_s, {1'b1, 1'b0, 4'd4, 1'b0, 1'b0, 1'b0}); end
    total = total + 1;
`ifdef ALU_ARB_STATS_EN
    if ({stat_gnt0, stat_gnt1} !== {16'd1, 16'd0}) begin bad = bad + 1; $display("FAIL stats_count got=%h exp=%h", {stat_gnt0, stat_gnt1}, {16'd1, 16'd0}); end
    total = total + 1;
`endif
    drain();
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_a = 4'd0; req0_b = 4'd0; req0_op = 3'd0;
    req1_valid = 1'b0; req1_a = 4'd0; req1_b = 4'd0; req1_op = 3'd0;
    rsp_ready = 1'b0;
    test_reset();
    test_single_add();
    test_sub();
    test_fairness();
    test_backpressure();
    test_illegal_op();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
